entry_fifo: RTL
===============

# entry_fifo

Output buffer between the fetch stage and the table-entry consumer. It accepts `TABLE_ENTRY` words from fetch via `ob_valid`/`ob_full`, holds them in order, and presents them to the downstream stage with a valid/ready handshake. It also supports a flush, used when fetch is redirected to a new address, and reports overflow if fetch writes while the buffer is full.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two, ≥ 4.
- `ENTRY_W`, default 128: width of a packed `TABLE_ENTRY`.
- `SKID`, default 2: number of free slots reserved for writes fetch already has in flight when it sees `ob_full`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discards all stored entries.
- `ob_valid`  in  1  fetch presents `entry` this cycle.
- `entry`  in  ENTRY_W  table entry from fetch.
- `ob_full`  out  1  back-pressure to fetch (registered).
- `out_valid`  out  1  `out_entry` holds a valid entry.
- `out_entry`  out  ENTRY_W  oldest stored entry (show-ahead).
- `out_ready`  in  1  consumer takes `out_entry` this cycle.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky flag: a write was dropped.

## Operation
- Storage is a `DEPTH`-entry array with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH). Pointers wrap modulo `DEPTH`. `count` is a separate register.
- Pop: `pop = out_valid & out_ready`. `out_entry = mem[rd_ptr]`. On a pop, `rd_ptr` increments.
- Push: `push = ob_valid & (count < DEPTH | pop)`. On a push, `entry` is written to `mem[wr_ptr]` and `wr_ptr` increments.
- Push and pop in the same cycle leave `count` unchanged. This includes the case `count == DEPTH`, where the pop frees the slot the push fills.
- Dropped write: `ob_valid & count == DEPTH & ~pop` discards the data and sets `overflow`. `overflow` clears only on `reset`.
- `ob_full` next-state is `(count_next >= DEPTH - SKID)`. It rises and falls with `count`, with no hysteresis.
- `out_valid` is `count != 0`, decoded from the `count` register.
- Flush:
  - Next cycle, `wr_ptr = rd_ptr = 0`, `count = 0`, `out_valid = 0`, `ob_full = 0`.
  - Flush overrides push and pop in the same cycle; the incoming entry is discarded without setting `overflow`.
  - Memory contents are not cleared.
- Reset: everything that flush clears, plus `overflow = 0` and all memory words = 0. `reset` overrides `flush`, `ob_valid` and `out_ready`.

## Timing
- Reset values:
  - `ob_full = 0`, `out_valid = 0`, `count = 0`, `overflow = 0`.
  - `out_entry = 0`, because `mem[0]` is zeroed.
- Write-to-read latency is 1 cycle. An entry pushed in cycle N is visible at `out_valid`/`out_entry` in N+1. There is no same-cycle bypass from an empty buffer.
- Sustained throughput is 1 push and 1 pop per cycle.
- `ob_full` reflects the state after the current cycle's push/pop and is visible in the next cycle. With `SKID = 2`, fetch may issue up to 2 more writes after `ob_full` rises without any data loss.
- Flush in cycle N: `out_valid = 0` in N+1. A push in N+1 is accepted normally.
- Reset asserted mid-stream: all outputs take their reset values in the next cycle, regardless of `ob_valid` and `out_ready`.
- Pointer wrap: after `DEPTH` pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with `out_ready = 0` -> `count = 3`, `out_entry = 0x11`, `out_valid = 1` from the cycle after the first push, `ob_full = 0`.
- Push until `count = 6` (`DEPTH = 8`, `SKID = 2`) -> `ob_full = 1` the next cycle. Two more pushes are accepted (`count = 8`). A 3rd push with no pop -> dropped, `overflow = 1`, `count` stays 8.
- `count = 8`, simultaneous push 0xAA and pop -> `count = 8`, popped value is the oldest entry, `overflow` stays 0, and 0xAA pops last.
- Continuous push/pop for 20 cycles with values 1..20 and `out_ready = 1` -> pointers wrap, outputs come out 1..20 in order at one per cycle, `count` stays ≤ 1.
- `count = 5`, assert `flush` with `ob_valid = 1` (0x55) -> next cycle `count = 0`, `out_valid = 0`, `ob_full = 0`, `overflow = 0`, and 0x55 is never output.
- Set `overflow`, then assert `flush` -> `overflow` stays 1. Assert `reset` together with `flush`/`ob_valid`/`out_ready` -> next cycle all outputs are 0.

Source files
------------

// File: rtl/entry_fifo.sv
// In-order output buffer between fetch and the table-entry consumer, with flush and sticky overflow.
// Latency: a push is visible at out_valid/out_entry one cycle later; there is no bypass when empty.
// Backpressure: registered ob_full asserts with SKID slots still free; writes arriving when full are dropped.
module entry_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 128,
  parameter int SKID    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ob_valid,
  input  logic [ENTRY_W-1:0]         entry,
  output logic                       ob_full,
  output logic                       out_valid,
  output logic [ENTRY_W-1:0]         out_entry,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - SKID);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_next;
  logic               pop;
  logic               push;
  logic               at_depth;

  assign out_valid = (count != '0);
  assign out_entry = mem[rd_ptr];
  assign at_depth  = (count == DEPTH_C);
  assign pop       = out_valid & out_ready;
  // A pop frees the slot a same-cycle push fills, so a full buffer still accepts.
  assign push      = ob_valid & (~at_depth | pop);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ob_full  <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is; only the bookkeeping is cleared.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ob_full <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (ob_valid && at_depth && !pop) begin
        overflow <= 1'b1;
      end
      count   <= count_next;
      ob_full <= (count_next >= FULL_TH);
    end
  end

endmodule
